// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for the RISC datapath.
// Fetches 32-bit instructions over a req/ack port, decodes them into register-file
// addresses, ALU function select and constant-unit controls, and maintains the PC.
// Ports:
//   CLK, RESET_n                 clock, async active-low reset
//   IMEM_REQ/IMEM_ADDR           fetch request and address (address = PC)
//   IMEM_ACK/IMEM_DATA           fetch acknowledge and instruction word
//   Z                            datapath zero flag for BZ
//   DA/AA/BA/FS/MB/IM/CS/RW      datapath controls, valid through EXEC
//   PC, HALT, ILLEGAL            program counter, halted flag, illegal-opcode pulse
module control_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        CLK,
   input  logic        RESET_n,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_DATA,
   input  logic        Z,
   output logic [4:0]  DA,
   output logic [4:0]  AA,
   output logic [4:0]  BA,
   output logic [4:0]  FS,
   output logic        MB,
   output logic [14:0] IM,
   output logic        CS,
   output logic        RW,
   output logic [31:0] PC,
   output logic        HALT,
   output logic        ILLEGAL
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RAW   = 5;
   localparam int unsigned IMW   = 15;
   localparam int unsigned OPW   = 7;

   localparam logic [OPW-1:0] OP_NOP = 7'h00;
   localparam logic [OPW-1:0] OP_BZ  = 7'h60;
   localparam logic [OPW-1:0] OP_HLT = 7'h7F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HLT
   } state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  ir_q, ir_d;
   logic             req_q, req_d;
   logic [RAW-1:0]   da_q, da_d, aa_q, aa_d, ba_q, ba_d, fs_q, fs_d;
   logic             mb_q, mb_d, cs_q, cs_d, rw_q, rw_d;
   logic [IMW-1:0]   im_q, im_d;
   logic             halt_q, halt_d, ill_q, ill_d, bz_q, bz_d;

   logic [OPW-1:0]   op_c;
   logic             is_alu_c;
   logic             known_c;

   // Opcode classification from the held instruction register
   always_comb begin
      op_c     = ir_q[31:25];
      is_alu_c = 1'b0;
      case (op_c)
         7'h02, 7'h05, 7'h08, 7'h0A,
         7'h22, 7'h25, 7'h28, 7'h2A: is_alu_c = 1'b1;
         default:                    is_alu_c = 1'b0;
      endcase
      known_c = is_alu_c || (op_c == OP_NOP) || (op_c == OP_BZ) || (op_c == OP_HLT);
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         req_q   <= 1'b0;
         da_q    <= '0;
         aa_q    <= '0;
         ba_q    <= '0;
         fs_q    <= '0;
         mb_q    <= 1'b0;
         cs_q    <= 1'b0;
         im_q    <= '0;
         rw_q    <= 1'b0;
         halt_q  <= 1'b0;
         ill_q   <= 1'b0;
         bz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         req_q   <= req_d;
         da_q    <= da_d;
         aa_q    <= aa_d;
         ba_q    <= ba_d;
         fs_q    <= fs_d;
         mb_q    <= mb_d;
         cs_q    <= cs_d;
         im_q    <= im_d;
         rw_q    <= rw_d;
         halt_q  <= halt_d;
         ill_q   <= ill_d;
         bz_q    <= bz_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      req_d   = req_q;
      da_d    = da_q;
      aa_d    = aa_q;
      ba_d    = ba_q;
      fs_d    = fs_q;
      mb_d    = mb_q;
      cs_d    = cs_q;
      im_d    = im_q;
      rw_d    = 1'b0;
      halt_d  = halt_q;
      ill_d   = 1'b0;
      bz_d    = bz_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            req_d   = 1'b1;
         end
         S_FETCH: begin
            if (IMEM_ACK) begin
               ir_d    = IMEM_DATA;
               req_d   = 1'b0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            da_d   = ir_q[24:20];
            aa_d   = ir_q[19:15];
            ba_d   = ir_q[14:10];
            im_d   = ir_q[14:0];
            fs_d   = is_alu_c ? op_c[4:0] : 5'd0;
            mb_d   = is_alu_c && op_c[5];
            // Sign-extend only for the add/subtract immediates
            cs_d   = is_alu_c && op_c[5] && ((op_c[4:0] == 5'b00010) || (op_c[4:0] == 5'b00101));
            rw_d   = is_alu_c;
            ill_d  = !known_c;
            bz_d   = (op_c == OP_BZ);
            if (op_c == OP_HLT) begin
               halt_d  = 1'b1;
               state_d = S_HLT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (bz_q && Z) begin
               pc_d = pc_q + XLEN'(1) + {{(XLEN-IMW){im_q[IMW-1]}}, im_q};
            end else begin
               pc_d = pc_q + XLEN'(1);
            end
            req_d   = 1'b1;
            state_d = S_FETCH;
         end
         S_HLT: begin
            state_d = S_HLT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign IMEM_REQ  = req_q;
   assign IMEM_ADDR = pc_q;
   assign PC        = pc_q;
   assign DA        = da_q;
   assign AA        = aa_q;
   assign BA        = ba_q;
   assign FS        = fs_q;
   assign MB        = mb_q;
   assign IM        = im_q;
   assign CS        = cs_q;
   assign RW        = rw_q;
   assign HALT      = halt_q;
   assign ILLEGAL   = ill_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: runs a small program from a bench-side
// instruction memory and checks controls, PC flow, wait states, halt and reset.
module tb_control_sequencer;

   logic        CLK = 1'b0;
   logic        RESET_n = 1'b0;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_ACK = 1'b1;
   logic [31:0] IMEM_DATA;
   logic        Z = 1'b0;
   logic [4:0]  DA, AA, BA, FS;
   logic        MB, CS, RW, HALT, ILLEGAL;
   logic [14:0] IM;
   logic [31:0] PC;

   logic [31:0] mem [0:31];
   int total = 0;
   int bad   = 0;

   control_sequencer dut (
      .CLK(CLK), .RESET_n(RESET_n),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
      .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
      .Z(Z),
      .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .IM(IM), .CS(CS), .RW(RW),
      .PC(PC), .HALT(HALT), .ILLEGAL(ILLEGAL)
   );

   always #5 CLK = ~CLK;

   assign IMEM_DATA = (IMEM_ADDR < 32'd32) ? mem[IMEM_ADDR[4:0]] : 32'h0;

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] dr,
                                       input logic [4:0] sa, input logic [14:0] low);
      return {op, dr, sa, low};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[2]  = enc(7'h22, 5'd3, 5'd4, 15'h7FFF);       // ADI
      mem[3]  = enc(7'h2A, 5'd1, 5'd2, 15'h4001);       // ORI
      mem[4]  = enc(7'h02, 5'd5, 5'd6, {5'd7, 10'd0});  // ADD
      mem[10] = enc(7'h60, 5'd0, 5'd0, 15'h7FFE);       // BZ -2
      mem[11] = enc(7'h13, 5'd1, 5'd1, 15'h0);          // illegal
      mem[12] = enc(7'h02, 5'd9, 5'd1, {5'd2, 10'd0});  // ADD, slow fetch
      mem[13] = enc(7'h7F, 5'd0, 5'd0, 15'h0);          // HLT

      // Reset values
      cyc(2);
      chk("rst_req",  32'(IMEM_REQ), 32'd0);
      chk("rst_pc",   PC, 32'd0);
      chk("rst_ctl",  32'({DA, AA, BA, FS, MB, CS, IM}), 32'd0);
      chk("rst_flag", 32'({RW, HALT, ILLEGAL}), 32'd0);

      RESET_n = 1'b1;                                   // release at negedge
      cyc(1);                                           // N1 FETCH 0
      chk("f0_req",  32'(IMEM_REQ), 32'd1);
      chk("f0_addr", IMEM_ADDR, 32'd0);
      cyc(1);
      chk("d0_req",  32'(IMEM_REQ), 32'd0);
      cyc(1);
      chk("nop0_rw", 32'(RW), 32'd0);
      cyc(1);                                           // N4 FETCH 1
      chk("f1_addr", IMEM_ADDR, 32'd1);
      chk("f1_req",  32'(IMEM_REQ), 32'd1);
      cyc(2);
      chk("nop1_rw", 32'(RW), 32'd0);
      cyc(1);
      chk("f2_addr", IMEM_ADDR, 32'd2);
      cyc(2);                                           // N9 EXEC ADI
      chk("adi_fs", 32'(FS), 32'h02);
      chk("adi_mb", 32'(MB), 32'd1);
      chk("adi_cs", 32'(CS), 32'd1);
      chk("adi_im", 32'(IM), 32'h7FFF);
      chk("adi_da", 32'(DA), 32'd3);
      chk("adi_aa", 32'(AA), 32'd4);
      chk("adi_rw", 32'(RW), 32'd1);
      cyc(1);                                           // N10 FETCH 3
      chk("f3_addr",  IMEM_ADDR, 32'd3);
      chk("f3_rw",    32'(RW), 32'd0);
      chk("hold_da",  32'(DA), 32'd3);
      cyc(2);                                           // N12 EXEC ORI
      chk("ori_cs", 32'(CS), 32'd0);
      chk("ori_mb", 32'(MB), 32'd1);
      chk("ori_fs", 32'(FS), 32'h0A);
      chk("ori_im", 32'(IM), 32'h4001);
      chk("ori_rw", 32'(RW), 32'd1);
      cyc(3);                                           // N15 EXEC ADD
      chk("add_mb", 32'(MB), 32'd0);
      chk("add_ba", 32'(BA), 32'd7);
      chk("add_fs", 32'(FS), 32'h02);
      chk("add_da", 32'(DA), 32'd5);
      chk("add_cs", 32'(CS), 32'd0);
      chk("add_rw", 32'(RW), 32'd1);
      cyc(16);                                          // N31 FETCH 10
      chk("f10_addr", IMEM_ADDR, 32'd10);
      Z = 1'b1;
      cyc(2);                                           // N33 EXEC BZ
      chk("bz_rw", 32'(RW), 32'd0);
      chk("bz_mb", 32'(MB), 32'd0);
      cyc(1);
      chk("bz_taken", IMEM_ADDR, 32'd9);
      Z = 1'b0;
      cyc(3);
      chk("f10b_addr", IMEM_ADDR, 32'd10);
      cyc(3);                                           // N40 FETCH 11
      chk("bz_fall", IMEM_ADDR, 32'd11);
      cyc(1);
      chk("ill_dec", 32'(ILLEGAL), 32'd0);
      cyc(1);                                           // N42 EXEC illegal
      chk("ill_exec", 32'(ILLEGAL), 32'd1);
      chk("ill_rw",   32'(RW), 32'd0);
      IMEM_ACK = 1'b0;
      cyc(1);                                           // N43 FETCH 12
      chk("ill_clr",  32'(ILLEGAL), 32'd0);
      chk("ill_pc",   IMEM_ADDR, 32'd12);
      cyc(4);                                           // N47 still fetching
      chk("ws_req",  32'(IMEM_REQ), 32'd1);
      chk("ws_addr", IMEM_ADDR, 32'd12);
      IMEM_ACK = 1'b1;
      cyc(1);
      chk("ws_dec_req", 32'(IMEM_REQ), 32'd0);
      cyc(1);                                           // N49 EXEC, 7th cycle
      chk("ws_rw", 32'(RW), 32'd1);
      chk("ws_da", 32'(DA), 32'd9);
      cyc(1);
      chk("f13_addr", IMEM_ADDR, 32'd13);
      cyc(2);                                           // N52 halted
      chk("hlt_halt", 32'(HALT), 32'd1);
      chk("hlt_req",  32'(IMEM_REQ), 32'd0);
      cyc(3);
      chk("hlt_halt2", 32'(HALT), 32'd1);
      chk("hlt_req2",  32'(IMEM_REQ), 32'd0);
      chk("hlt_pc",    PC, 32'd13);
      chk("hlt_rw",    32'(RW), 32'd0);

      // Reset out of halt
      RESET_n = 1'b0;
      #1;
      chk("rh_halt", 32'(HALT), 32'd0);
      chk("rh_pc",   PC, 32'd0);
      cyc(1);
      RESET_n = 1'b1;
      cyc(1);
      chk("r2_f0", IMEM_ADDR, 32'd0);
      cyc(2);
      IMEM_ACK = 1'b0;
      cyc(2);                                           // FETCH 1, stalled
      chk("mf_req",  32'(IMEM_REQ), 32'd1);
      chk("mf_addr", IMEM_ADDR, 32'd1);
      RESET_n = 1'b0;
      IMEM_ACK = 1'b1;
      #1;
      chk("mf_req_drop", 32'(IMEM_REQ), 32'd0);
      chk("mf_pc",       PC, 32'd0);
      cyc(2);
      chk("mf_req_hold", 32'(IMEM_REQ), 32'd0);
      RESET_n = 1'b1;
      cyc(1);
      chk("mf_refetch", 32'({31'd0, IMEM_REQ} | (IMEM_ADDR << 1)), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
